// File: rtl/q8_8_pkg.sv
// Shared Q8.8 definitions: word format, op codes and the result-buffer state encoding.
package q8_8_pkg;

  localparam int Q88_WIDTH = 16;
  localparam int Q88_FRAC  = 8;
  localparam logic [Q88_WIDTH-1:0] Q88_MAX = 16'hFFFF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/q8_8_narrow.sv
// Narrows a 17-bit raw add/sub result to Q8.8 and flags add overflow.
// Q8_8_RESULT_SAT_EN selects clamping to all-ones; otherwise overflowing results wrap.
module q8_8_narrow
  import q8_8_pkg::*;
#(
  parameter int W = Q88_WIDTH
) (
  input  logic [W:0]   result,
  input  logic         add_sub,
  output logic [W-1:0] data,
  output logic         ovf
);

  // A carry on a subtract cannot come from a valid magnitude and is dropped silently.
  assign ovf = (add_sub == OP_ADD) && result[W];

`ifdef Q8_8_RESULT_SAT_EN
  assign data = ovf ? {W{1'b1}} : result[W-1:0];
`else
  assign data = result[W-1:0];
`endif

endmodule

// File: rtl/q8_8_result_stage.sv
// Registered Q8.8 result stage: narrowing, 2-entry skid buffer and overflow status.
// Overflow saturation is enabled by defining Q8_8_RESULT_SAT_EN.
module q8_8_result_stage
  import q8_8_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH:0]   in_result,
  input  logic                 in_add_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 sticky_ovf,
  output logic [CNT_WIDTH-1:0] ovf_count,
  input  logic                 stat_clr
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  buf_state_e state, state_next;

  logic [BUS_WIDTH-1:0] head_data, tail_data, nar_data;
  logic                 head_ovf, tail_ovf, nar_ovf;
  logic                 accept, produce;

  q8_8_narrow #(.W(BUS_WIDTH)) u_narrow (
    .result  (in_result),
    .add_sub (in_add_sub),
    .data    (nar_data),
    .ovf     (nar_ovf)
  );

  assign accept  = in_valid && in_ready;
  assign produce = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !produce)      state_next = FULL;
        else if (!accept && produce) state_next = EMPTY;
      end
      FULL:    if (produce) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // in_ready looks only at registered state, never at out_ready.
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = !rst && (state != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_data <= '0;
      head_ovf  <= 1'b0;
      tail_data <= '0;
      tail_ovf  <= 1'b0;
    end else begin
      if (accept && (state == EMPTY || (state == ONE && produce))) begin
        head_data <= nar_data;
        head_ovf  <= nar_ovf;
      end else if (accept && state == ONE) begin
        tail_data <= nar_data;
        tail_ovf  <= nar_ovf;
      end else if (produce && state == FULL) begin
        head_data <= tail_data;
        head_ovf  <= tail_ovf;
      end
    end
  end

  assign out_data = head_data;
  assign out_ovf  = head_ovf;

  // An accepted overflow beats a same-cycle clear, leaving a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && nar_ovf) begin
      sticky_ovf <= 1'b1;
      if (stat_clr)               ovf_count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else if (ovf_count != '1)   ovf_count <= ovf_count + 1'b1;
    end else if (stat_clr) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_q8_8_result_stage.sv
// Directed bench for q8_8_result_stage with an expected-queue scoreboard on the output side.
module tb_q8_8_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_result;
  logic        in_add_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        sticky_ovf;
  logic [7:0]  ovf_count;
  logic        stat_clr;

  logic [16:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

`ifdef Q8_8_RESULT_SAT_EN
  localparam logic [15:0] OVF_10000 = 16'hFFFF;
  localparam logic [15:0] OVF_18001 = 16'hFFFF;
`else
  localparam logic [15:0] OVF_10000 = 16'h0000;
  localparam logic [15:0] OVF_18001 = 16'h8001;
`endif

  q8_8_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_add_sub (in_add_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .sticky_ovf (sticky_ovf),
    .ovf_count  (ovf_count),
    .stat_clr   (stat_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a produce happens at the next rising edge, so compare the head now.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected none", {out_ovf, out_data});
      end else begin
        check("out_entry", {15'd0, out_ovf, out_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one result; the expected response is queued on the cycle it is accepted.
  task automatic send(input logic [16:0] res, input logic op, input logic [15:0] exp_d, input logic exp_o);
    bit done = 0;
    in_valid   = 1'b1;
    in_result  = res;
    in_add_sub = op;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_o, exp_d});
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", res);
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_add_sub = 1'b0;
    out_ready = 1'b0; stat_clr = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {16'd0, out_data}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_count", {24'd0, ovf_count}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 1);
    tick();

    // Overflowing add: 0x8000 + 0x8000
    out_ready = 1'b1;
    send(17'h10000, 1'b0, OVF_10000, 1'b1);
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 1);
    check("ovf_sticky", {31'd0, sticky_ovf}, 1);
    check("ovf_count_1", {24'd0, ovf_count}, 1);
    tick();

    // Subtracts never count as overflow, even with an illegal carry
    send(17'h00180, 1'b1, 16'h0180, 1'b0);
    send(17'h10005, 1'b1, 16'h0005, 1'b0);
    tick();
    @(negedge clk);
    check("sub_count_unchanged", {24'd0, ovf_count}, 1);
    tick();

    // Back-pressure: two fill the buffer, the third is held off
    out_ready = 1'b0;
    send(17'h00100, 1'b0, 16'h0100, 1'b0);
    send(17'h00200, 1'b0, 16'h0200, 1'b0);
    in_valid = 1'b1; in_result = 17'h00300; in_add_sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_in_ready", {31'd0, in_ready}, 0);
      check("full_head_stable", {16'd0, out_data}, 16'h0100);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(17'h00300, 1'b0, 16'h0300, 1'b0);

    // Streaming overflows: one accept per cycle, counter saturates
    acc = 0;
    in_valid = 1'b1; in_result = 17'h18001; in_add_sub = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({1'b1, OVF_18001});
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_throughput", acc, 300);
    @(negedge clk);
    check("stream_count_sat", {24'd0, ovf_count}, 8'hFF);
    check("stream_sticky", {31'd0, sticky_ovf}, 1);
    tick();

    // Clear coinciding with an accepted overflow, then a clear alone
    stat_clr = 1'b1;
    send(17'h10000, 1'b0, OVF_10000, 1'b1);
    stat_clr = 1'b0;
    @(negedge clk);
    check("clr_ovf_count", {24'd0, ovf_count}, 1);
    check("clr_ovf_sticky", {31'd0, sticky_ovf}, 1);
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    check("clr_count", {24'd0, ovf_count}, 0);
    check("clr_sticky", {31'd0, sticky_ovf}, 0);
    tick();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    send(17'h10000, 1'b0, OVF_10000, 1'b1);
    send(17'h00400, 1'b0, 16'h0400, 1'b0);
    @(negedge clk);
    check("pre_rst_full", {31'd0, in_ready}, 0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_out_data", {16'd0, out_data}, 0);
    check("midrst_count", {24'd0, ovf_count}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", {31'd0, in_ready}, 1);
    check("after_rst_out_valid", {31'd0, out_valid}, 0);
    tick();
    out_ready = 1'b1;
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/q8_8_result_stage.md
# q8_8_result_stage

Registered output stage that sits directly downstream of the Q8.8 add/subtract unit. Takes its 17-bit raw result (16-bit Q8.8 magnitude plus carry bit) and the operation code, then narrows the result to 16-bit Q8.8 with saturation and overflow detection. Results are buffered in a 2-entry skid buffer with valid/ready handshakes on both sides. The stage also keeps a sticky overflow flag and a saturating overflow counter for status reads.

## Interface
- BUS_WIDTH, 16, Q8.8 word width; the input is BUS_WIDTH+1 bits wide.
- CNT_WIDTH, 8, width of the overflow event counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- in_result  input  BUS_WIDTH+1  raw adder/subtractor result; bit BUS_WIDTH is the carry.
- in_add_sub  input  1  op code that produced in_result: 0 = add, 1 = subtract (magnitude).
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  BUS_WIDTH  Q8.8 result.
- out_ovf  output  1  overflow flag for the current out_data.
- sticky_ovf  output  1  set by any overflow since reset or clear.
- ovf_count  output  CNT_WIDTH  number of accepted overflowing results; saturates at all-ones.
- stat_clr  input  1  clears sticky_ovf and ovf_count.

## Operation
- Accept rule: a result is accepted on a cycle with in_valid && in_ready. Produce rule: a result is produced on a cycle with out_valid && out_ready.
- Overflow is in_add_sub == 0 && in_result[BUS_WIDTH] == 1.
  - Subtract results never overflow.
  - If subtract input has carry bit set (illegal), it is ignored, truncated and not flagged.
- Narrowing:
  - Without overflow, data = in_result[BUS_WIDTH-1:0].
  - With overflow, data is set per Configuration.
- Buffer FSM states are EMPTY, ONE and FULL, with 2 entries held in FIFO order.
  - EMPTY: accept moves to ONE.
  - ONE: accept only moves to FULL. Produce only moves to EMPTY. Accept and produce in the same cycle stays in ONE; the head is replaced by the new entry.
  - FULL: in_ready = 0. Produce moves to ONE, and the second entry becomes the head.
- out_data and out_ovf always reflect the head entry; out_valid = (state != EMPTY).
- Status counters:
  - On each accepted overflow: sticky_ovf <= 1 and ovf_count increments, holding at 2^CNT_WIDTH-1.
  - stat_clr without an accepted overflow sets both to 0.
  - stat_clr with an accepted overflow in the same cycle: overflow wins, giving sticky_ovf = 1 and ovf_count = 1.
- Output stability: while out_valid && !out_ready, out_data and out_ovf hold stable.

## Timing
- Latency: accept on edge N gives out_valid high after edge N, i.e. 1 cycle.
- Throughput: 1 result/cycle when out_ready stays high.
- in_ready is decoded from registered state only; there is no combinational path from out_ready to in_ready. In FULL, in_ready is 0 even if out_ready = 1 that cycle.
- Reset:
  - When rst is sampled high, the next state is EMPTY, out_valid = 0, out_data = 0, out_ovf = 0, sticky_ovf = 0 and ovf_count = 0.
  - in_ready = 0 while rst is high and 1 from the first cycle after.
  - Buffered entries are discarded on reset mid-operation.
- in_valid, in_ready, out_valid and out_ready are all sampled only at rising clk.

## Configuration
- Q8_8_RESULT_SAT_EN:
  - Defined: overflowing results are clamped to all-ones (16'hFFFF = 255.99609375).
  - Undefined: overflowing results wrap, out_data = in_result[BUS_WIDTH-1:0].
  - out_ovf, sticky_ovf and ovf_count behave identically in both builds.

## Structure
- Shared package q8_8_pkg holds:
  - Q88_WIDTH = 16 and Q88_FRAC = 8.
  - Q88_MAX = 16'hFFFF.
  - Op codes OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - The buffer state encoding EMPTY/ONE/FULL.
- One combinational sub-module, q8_8_narrow, does the carry check and saturate/wrap. The 2-entry buffer, FSM and status logic stay in the top module.

## Test plan
- Add 0x8000+0x8000, in_result = 17'h10000, out_ready = 1:
  - With SAT_EN: out_data = 0xFFFF one cycle later, out_ovf = 1, sticky_ovf = 1, ovf_count = 1.
  - Without SAT_EN: out_data = 0x0000, flags the same.
- Subtract result 17'h00180 (1.5): out_data = 0x0180, out_ovf = 0, status unchanged.
- out_ready = 0 while pushing 3 results (0x0100, 0x0200, 0x0300):
  - in_ready drops after the 2nd accept and the 3rd is held upstream.
  - Raising out_ready then drains 0x0100, 0x0200, 0x0300 in order.
- Streaming 300 overflowing adds back-to-back: ovf_count saturates at 0xFF and throughput is 1/cycle.
- stat_clr in the same cycle as an accepted overflow: ovf_count = 1, sticky_ovf = 1. stat_clr alone the next cycle gives ovf_count = 0, sticky_ovf = 0.
- rst asserted while FULL: next cycle out_valid = 0, out_data = 0, ovf_count = 0. in_ready = 1 the cycle after rst deasserts.
